// File: rtl/neuron_pkg.sv
// Shared constants, enable-vector layout, bus map and FSM encoding for the neuron MAC engine.
package neuron_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_TAPS = 20;
  localparam int ACC_W  = 40;
  localparam int IDX_W  = $clog2(N_TAPS);
  localparam int N_EN   = N_TAPS + 2;

  localparam int EN_COEF0  = 0;
  localparam int EN_OFFSET = 20;
  localparam int EN_INPUT  = 21;

  localparam logic [11:0] ADDR_COEF0     = 12'h00C;
  localparam logic [11:0] ADDR_COEF_LAST = 12'h058;
  localparam logic [11:0] ADDR_OFFSET    = 12'h05C;
  localparam logic [11:0] ADDR_INPUT     = 12'h060;
  localparam logic [11:0] ADDR_START     = 12'h08C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] value;
  } sat_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Drops the fraction with a floor shift, then clamps to the signed DATA_W range.
  function automatic sat_t saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    sat_t r;
    s = acc >>> FRAC_W;
    if (s > SAT_MAX) begin
      r.ovf   = 1'b1;
      r.value = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s < SAT_MIN) begin
      r.ovf   = 1'b1;
      r.value = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r.ovf   = 1'b0;
      r.value = s[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_tap_line.sv
// Input delay line: a push puts the new word in tap 0 and ages the rest by one slot.
// Frozen while hold is high so the MAC reads a stable vector.
module neuron_tap_line #(
  parameter int DATA_W = 16,
  parameter int N_TAPS = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           hold,
  input  logic [DATA_W-1:0]              din,
  output logic [N_TAPS-1:0][DATA_W-1:0]  taps
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (push && !hold) begin
      taps <= {taps[N_TAPS-2:0], din};
    end
  end

endmodule

// File: rtl/neuron_mac_engine.sv
// Coefficient bank plus sequential 1-MAC/cycle dot product with offset, saturated Q result.
// Busy for N_TAPS+1 cycles per start; bank writes and starts are ignored while busy.
module neuron_mac_engine
  import neuron_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Write,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [N_EN-1:0]   EnableRegister,
  input  logic              EnableStart,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic              Clase,
  output logic              Overflow
);

  state_t                         state, state_nxt;
  logic [N_TAPS-1:0][DATA_W-1:0]  coef;
  logic [DATA_W-1:0]              offset;
  logic [N_TAPS-1:0][DATA_W-1:0]  taps;
  logic [IDX_W-1:0]               idx;
  logic signed [ACC_W-1:0]        acc;
  logic signed [2*DATA_W-1:0]     prod;
  logic                           idle;
  logic                           start;
  sat_t                           sat;

  assign idle  = (state == IDLE);
  assign start = EnableStart & Write & idle;
  assign prod  = $signed(coef[idx]) * $signed(taps[idx]);
  assign sat   = saturate(acc);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (idx == IDX_W'(N_TAPS-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = !idle;
  end

  // Enables arrive pre-gated by Write; only the IDLE qualifier is applied here.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      coef   <= '0;
      offset <= '0;
    end else if (idle) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (EnableRegister[EN_COEF0+k]) coef[k] <= WriteData;
      end
      if (EnableRegister[EN_OFFSET]) offset <= WriteData;
    end
  end

  neuron_tap_line #(
    .DATA_W (DATA_W),
    .N_TAPS (N_TAPS)
  ) u_tap_line (
    .clk  (Clock),
    .rst  (Reset),
    .push (EnableRegister[EN_INPUT]),
    .hold (!idle),
    .din  (WriteData),
    .taps (taps)
  );

  // Published outputs change only in FINISH, so a reset mid-run never exposes a partial sum.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx      <= '0;
      acc      <= '0;
      Done     <= 1'b0;
      Result   <= '0;
      Clase    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx  <= '0;
            acc  <= {{(ACC_W-DATA_W-FRAC_W){offset[DATA_W-1]}}, offset, {FRAC_W{1'b0}}};
            Done <= 1'b0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
          idx <= idx + 1'b1;
        end
        FINISH: begin
          Result   <= sat.value;
          Overflow <= sat.ovf;
          Clase    <= ~acc[ACC_W-1];
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
